// File: rtl/breakdown_ctrl.sv
// -----------------------------------------------------------------------------
// breakdown_ctrl
//
// Per-channel link breakdown monitor. Each channel counts valid flits that
// carry a nonzero packet number. When the count reaches BREAKDOWN_NUM the
// channel raises a registered breakdown reset request (fault_o).
//
// Build option:
//   BREAKDOWN_RECOVER_EN  defined   -> fault lasts HOLD_CYCLES cycles, then one
//                                      HOLD cycle clears the counter, then the
//                                      channel counts again.
//                         undefined -> fault is sticky until clr or rst; no
//                                      hold timer is built.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   arm          global counting enable
//   clr          synchronous clear of all counters and faults (highest priority)
//   data_i       CH_NUM flits, channel c at [c*DATA_W +: DATA_W]
//   valid_i      per-channel flit valid
//   fault_o      per-channel breakdown reset request (registered)
//   any_fault_o  OR of fault_o (combinational)
//   count_o      per-channel packet counters, channel c at [c*CNT_W +: CNT_W]
//
// Per-channel FSM:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_COUNT | counting qualified flits, watching for the threshold
//   ST_FAULT | fault_o asserted, counter frozen
//   ST_HOLD  | (recover build) one cycle with fault_o low and counter zeroed
// -----------------------------------------------------------------------------
module breakdown_ctrl #(
    parameter int CH_NUM        = 4,
    parameter int DATA_W        = 66,
    parameter int PNUM_HI       = 63,
    parameter int PNUM_LO       = 48,
    parameter int CNT_W         = 16,
    parameter int BREAKDOWN_NUM = 50,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       clr,
    input  logic [CH_NUM*DATA_W-1:0]   data_i,
    input  logic [CH_NUM-1:0]          valid_i,
    output logic [CH_NUM-1:0]          fault_o,
    output logic                       any_fault_o,
    output logic [CH_NUM*CNT_W-1:0]    count_o
);

    localparam int               PNUM_W  = PNUM_HI - PNUM_LO + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      THRESH  = 32'(BREAKDOWN_NUM);
    localparam bit               TRIG_EN = (BREAKDOWN_NUM != 0);
`ifdef BREAKDOWN_RECOVER_EN
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_FAULT = 2'd1
`ifdef BREAKDOWN_RECOVER_EN
        , ST_HOLD = 2'd2
`endif
    } state_t;

    // Only the packet-number field of each flit matters; the payload is
    // deliberately ignored.
    logic unused_payload;
    assign unused_payload = ^data_i;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        state_t            state;
        logic [CNT_W-1:0]  cnt;
        logic              fault;
        logic [PNUM_W-1:0] pnum;
        logic              hit;
        logic              trig;
`ifdef BREAKDOWN_RECOVER_EN
        logic [7:0]        hold_tmr;
`endif

        assign pnum = data_i[c*DATA_W + PNUM_LO +: PNUM_W];
        assign hit  = arm && valid_i[c] && (pnum != '0);
        // Threshold is taken from the registered count, so fault_o rises
        // one cycle after the count reaches BREAKDOWN_NUM.
        assign trig = TRIG_EN && (32'(cnt) >= THRESH);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= ST_COUNT;
                cnt      <= '0;
                fault    <= 1'b0;
`ifdef BREAKDOWN_RECOVER_EN
                hold_tmr <= '0;
`endif
            end else if (clr) begin
                state    <= ST_COUNT;
                cnt      <= '0;
                fault    <= 1'b0;
`ifdef BREAKDOWN_RECOVER_EN
                hold_tmr <= '0;
`endif
            end else begin
                case (state)
                    ST_COUNT: begin
                        if (hit && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
                        if (trig) begin
                            state    <= ST_FAULT;
                            fault    <= 1'b1;
`ifdef BREAKDOWN_RECOVER_EN
                            hold_tmr <= HOLD_LOAD;
`endif
                        end
                    end
                    ST_FAULT: begin
`ifdef BREAKDOWN_RECOVER_EN
                        // Down-counter: terminal count ends the fault window.
                        if (hold_tmr == '0) begin
                            state <= ST_HOLD;
                            fault <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            hold_tmr <= hold_tmr - 1'b1;
                        end
`endif
                    end
`ifdef BREAKDOWN_RECOVER_EN
                    ST_HOLD: state <= ST_COUNT;
`endif
                    default: begin
                        state <= ST_COUNT;
                        fault <= 1'b0;
                    end
                endcase
            end
        end

        assign fault_o[c]                 = fault;
        assign count_o[c*CNT_W +: CNT_W] = cnt;
    end

    assign any_fault_o = |fault_o;

endmodule

// File: doc/breakdown_ctrl.md
BREAKDOWN_CTRL -- requirements
Module: breakdown_ctrl

Interface
REQ-001 The module SHALL have parameter CH_NUM, default 4, meaning the number of monitored link channels.
REQ-002 The module SHALL have parameter DATA_W, default 66, meaning the flit width per channel.
REQ-003 The module SHALL have parameter PNUM_HI, default 63, and PNUM_LO, default 48, meaning the packet-number field bounds within a flit.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning the per-channel counter width.
REQ-005 The module SHALL have parameter BREAKDOWN_NUM, default 50, meaning the packet count that triggers breakdown; a value of 0 disables triggering.
REQ-006 The module SHALL have parameter HOLD_CYCLES, default 8, meaning the fault duration in recover mode (range 1..255).
REQ-007 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-008 The module SHALL have port rst, input, 1 bit; one clock, and reset is asynchronous and active-high.
REQ-009 The module SHALL have port arm, input, 1 bit, the global counting enable.
REQ-010 The module SHALL have port clr, input, 1 bit, the synchronous clear of all counters and faults.
REQ-011 The module SHALL have port data_i, input, CH_NUM*DATA_W bits, with channel c at bits [c*DATA_W +: DATA_W].
REQ-012 The module SHALL have port valid_i, input, CH_NUM bits, the per-channel flit-valid strobe.
REQ-013 The module SHALL have port fault_o, output, CH_NUM bits, the per-channel breakdown reset request (active-high).
REQ-014 The module SHALL have port any_fault_o, output, 1 bit, the OR of fault_o.
REQ-015 The module SHALL have port count_o, output, CH_NUM*CNT_W bits, the per-channel packet counters.

Function
REQ-016 Each channel SHALL run an independent FSM with states COUNT and FAULT, plus HOLD when the configuration macro is defined.
REQ-017 In COUNT, cnt[c] SHALL increment by 1 on a clock edge when arm=1, valid_i[c]=1, and the channel's packet-number field [PNUM_HI:PNUM_LO] is nonzero; otherwise cnt[c] SHALL hold.
REQ-018 cnt[c] SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-019 In COUNT with BREAKDOWN_NUM!=0 and registered cnt[c]>=BREAKDOWN_NUM, the channel SHALL enter FAULT on the next edge, with fault_o[c] registered and asserted one cycle after the count reaches the threshold.
REQ-020 In FAULT, cnt[c] SHALL be frozen and fault_o[c] SHALL be 1.
REQ-021 clr=1 SHALL, at the next edge, zero every cnt, deassert every fault_o, and return every FSM to COUNT; clr SHALL have priority over increments and FSM transitions in the same cycle.
REQ-022 any_fault_o SHALL be combinational OR of fault_o with no added latency.
REQ-023 Simultaneous threshold hits on several channels SHALL fault each channel independently in the same cycle.

Reset
REQ-024 While rst=1, all cnt SHALL be 0, fault_o SHALL be 0, any_fault_o SHALL be 0, hold timers SHALL be 0, and FSMs SHALL be in COUNT, asynchronously.
REQ-025 Assertion of rst mid-FAULT or mid-HOLD SHALL immediately clear fault_o; after rst deasserts, counting SHALL resume from 0 on the first edge.

Configuration
REQ-026 Macro BREAKDOWN_RECOVER_EN SHALL select recover mode: FAULT SHALL persist exactly HOLD_CYCLES cycles, then the channel SHALL pass through HOLD for one cycle (fault_o=0, cnt cleared), then return to COUNT.
REQ-027 Without BREAKDOWN_RECOVER_EN, FAULT SHALL be sticky until clr or rst, and no hold timer logic SHALL be synthesised.

Verification
REQ-028 With arm=1, 50 valid flits with packet_num=0x0001 on ch0 -> count_o[ch0]=50 and fault_o[0]=1 one cycle later; other channels remain 0.
REQ-029 Flits with packet_num=0x0000, or with valid_i=0, or with arm=0 -> count unchanged; fault_o stays 0.
REQ-030 Recover build, HOLD_CYCLES=8, ch2 triggered -> fault_o[2]=1 for exactly 8 cycles, then count_o[ch2]=0 and counting resumes.
REQ-031 Sticky build, ch1 faulted, 100 idle cycles -> fault_o[1] still 1; pulse clr -> fault_o=0 and all counts 0 the next cycle.
REQ-032 CNT_W=4, BREAKDOWN_NUM=0, 20 valid flits -> count_o saturates at 15 and no fault occurs.
REQ-033 rst asserted mid-fault, asynchronously between edges -> fault_o and any_fault_o drop before the next clock edge.
